// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - RV32I opcodes, instruction-type codes and immediate range limits
package rv32i_pkg;

  // Major opcodes, shared with the opcode type decoder
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Instruction-type codes on the request interface; 6 and 7 are illegal
  typedef enum logic [2:0] {
    TYPE_R      = 3'd0,
    TYPE_I      = 3'd1,
    TYPE_LOAD   = 3'd2,
    TYPE_STORE  = 3'd3,
    TYPE_BRANCH = 3'd4,
    TYPE_JAL    = 3'd5
  } instr_type_e;

  // Signed byte-offset limits for each immediate format
  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int IMM13_MIN = -4096;
  localparam int IMM13_MAX = 4094;
  localparam int IMM21_MIN = -1048576;
  localparam int IMM21_MAX = 1048574;

  function automatic logic imm_in_range(input logic [31:0] imm, input int lo, input int hi);
    return ($signed(imm) >= lo) && ($signed(imm) <= hi);
  endfunction

endpackage

// File: rtl/instr_format_enc.sv
// rtl/instr_format_enc.sv - combinational RV32I field packer with illegal/range flags
module instr_format_enc
  import rv32i_pkg::*;
(
  input  logic [2:0]  type_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [31:0] imm_i,
  output logic [31:0] word_o,
  output logic        illegal_o,
  output logic        range_o
);

  instr_type_e ty;
  assign ty = instr_type_e'(type_i);

  // Pack fields per format; an illegal type never raises the range flag
  always_comb begin
    word_o    = '0;
    illegal_o = 1'b0;
    range_o   = 1'b0;
    case (ty)
      TYPE_R: begin
        word_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, OP_R};
      end
      TYPE_I: begin
        word_o  = {imm_i[11:0], rs1_i, funct3_i, rd_i, OP_I};
        range_o = !imm_in_range(imm_i, IMM12_MIN, IMM12_MAX);
      end
      TYPE_LOAD: begin
        word_o  = {imm_i[11:0], rs1_i, funct3_i, rd_i, OP_LOAD};
        range_o = !imm_in_range(imm_i, IMM12_MIN, IMM12_MAX);
      end
      TYPE_STORE: begin
        word_o  = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], OP_STORE};
        range_o = !imm_in_range(imm_i, IMM12_MIN, IMM12_MAX);
      end
      TYPE_BRANCH: begin
        word_o  = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                   imm_i[4:1], imm_i[11], OP_BRANCH};
        range_o = !imm_in_range(imm_i, IMM13_MIN, IMM13_MAX) || imm_i[0];
      end
      TYPE_JAL: begin
        word_o  = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, OP_JAL};
        range_o = !imm_in_range(imm_i, IMM21_MIN, IMM21_MAX) || imm_i[0];
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - handshake front end that encodes RV32I words into imem
module instr_encoder
  import rv32i_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_type,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              err_illegal,
  output logic              err_range
);

  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              err_ill_q;
  logic              err_rng_q;

  logic [31:0] enc_word;
  logic        enc_illegal;
  logic        enc_range;
  logic        accept;
  logic        legal_write;

  instr_format_enc u_fmt (
    .type_i   (in_type),
    .rd_i     (in_rd),
    .rs1_i    (in_rs1),
    .rs2_i    (in_rs2),
    .funct3_i (in_funct3),
    .funct7_i (in_funct7),
    .imm_i    (in_imm),
    .word_o   (enc_word),
    .illegal_o(enc_illegal),
    .range_o  (enc_range)
  );

  assign full        = (count_q == DEPTH_CNT);
  assign in_ready    = !full && !clear;
  assign accept      = in_valid && in_ready;
  assign legal_write = accept && !enc_illegal && !enc_range;

  // Pointer/count next state: clear rewinds, a legal write advances (ptr wraps naturally)
  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    if (clear) begin
      ptr_d   = '0;
      count_d = '0;
    end else if (legal_write) begin
      ptr_d   = ptr_q + 1'b1;
      count_d = count_q + 1'b1;
    end
  end

  // Register write strobe, address, data and one-cycle error pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= '0;
      count_q   <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      err_ill_q <= 1'b0;
      err_rng_q <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      count_q   <= count_d;
      we_q      <= legal_write;
      err_ill_q <= accept && enc_illegal;
      err_rng_q <= accept && !enc_illegal && enc_range;
      if (legal_write) begin
        addr_q  <= ptr_q;
        wdata_q <= enc_word;
      end
    end
  end

  assign imem_we     = we_q;
  assign imem_addr   = addr_q;
  assign imem_wdata  = wdata_q;
  assign count       = count_q;
  assign err_illegal = err_ill_q;
  assign err_range   = err_rng_q;

endmodule
